// File: rtl/hud_pkg.sv
// Purpose: shared types, screen timing constants and colour helpers for the heart HUD.
// Latency: n/a (declarations only). Backpressure: none.
// Contents: life_state_e FSM encoding, KEY_COLOR_DEFAULT, H_ACTIVE/V_ACTIVE, LIVES_W, rgb565_dim().
package hud_pkg;

  typedef enum logic [1:0] {
    ALIVE = 2'd0,
    HIT   = 2'd1,
    OVER  = 2'd2
  } life_state_e;

  localparam logic [15:0] KEY_COLOR_DEFAULT = 16'hF81F;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  // Width of the lives counter as seen on the block boundary.
  localparam int LIVES_W = 2;

  // Quarter brightness: each of R5/G6/B5 logically shifted right by 2.
  function automatic logic [15:0] rgb565_dim(input logic [15:0] c);
    return {2'b00, c[15:13], 2'b00, c[10:7], 2'b00, c[4:2]};
  endfunction

endpackage

// File: rtl/heart_hud_ctrl_if.sv
// Purpose: bundles raster position, game events, heart ROM port and HUD outputs.
// Latency: n/a (wiring only). Backpressure: none, all signals are free-running.
// Modports: master = video timing / game logic / ROM side, slave = heart_hud_ctrl.
interface heart_hud_if;
  import hud_pkg::*;

  logic [9:0]         vga_x;
  logic [9:0]         vga_y;
  logic               video_on;
  logic               life_lost;
  logic               life_gain;
  logic               game_restart;
  logic [3:0]         rom_x;
  logic [3:0]         rom_y;
  logic [15:0]        rom_rgb;
  logic [15:0]        rgb;
  logic               pix_valid;
  logic [LIVES_W-1:0] lives;
  logic               hit_active;
  logic               game_over;

  modport master (
    output vga_x, vga_y, video_on, life_lost, life_gain, game_restart, rom_rgb,
    input  rom_x, rom_y, rgb, pix_valid, lives, hit_active, game_over
  );

  modport slave (
    input  vga_x, vga_y, video_on, life_lost, life_gain, game_restart, rom_rgb,
    output rom_x, rom_y, rgb, pix_valid, lives, hit_active, game_over
  );

endinterface

// File: rtl/hud_life_fsm.sv
// Purpose: lives counter, ALIVE/HIT/OVER sequencing, invulnerability blink and per-frame lives snapshot.
// Latency: lives/flags update 1 cycle after a pulse; lives_disp updates on the frame tick. Backpressure: none.
// Ports: vga_clk, sys_rst_n, frame_tick, life_lost/life_gain/game_restart in; lives, lives_disp, state, blink_phase, hit_active, game_over out.
module hud_life_fsm
  import hud_pkg::*;
#(
  parameter int MAX_LIVES    = 3,
  parameter int BLINK_FRAMES = 60,
  parameter int BLINK_BIT    = 2
) (
  input  logic               vga_clk,
  input  logic               sys_rst_n,
  input  logic               frame_tick,
  input  logic               life_lost,
  input  logic               life_gain,
  input  logic               game_restart,
  output logic [LIVES_W-1:0] lives,
  output logic [LIVES_W-1:0] lives_disp,
  output life_state_e        state,
  output logic               blink_phase,
  output logic               hit_active,
  output logic               game_over
);

  localparam int BW = $clog2(BLINK_FRAMES + 1);
  localparam logic [LIVES_W-1:0] MAXL = LIVES_W'(MAX_LIVES);

  life_state_e        state_q, state_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [LIVES_W-1:0] lives_disp_q, lives_disp_d;
  logic [BW-1:0]      blink_q, blink_d;
  logic               hit_active_q, hit_active_d;
  logic               game_over_q, game_over_d;

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= ALIVE;
      lives_q      <= MAXL;
      lives_disp_q <= MAXL;
      blink_q      <= '0;
      hit_active_q <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      lives_q      <= lives_d;
      lives_disp_q <= lives_disp_d;
      blink_q      <= blink_d;
      hit_active_q <= hit_active_d;
      game_over_q  <= game_over_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    blink_d = blink_q;
    // Snapshot only at the frame boundary so a frame never shows two counts.
    lives_disp_d = frame_tick ? lives_q : lives_disp_q;

    if (game_restart) begin
      lives_d = MAXL;
      blink_d = '0;
      state_d = ALIVE;
    end else begin
      case (state_q)
        ALIVE: begin
          if (life_lost) begin
            // A gain arriving with the hit is intentionally discarded.
            if (lives_q > LIVES_W'(1)) begin
              lives_d = lives_q - LIVES_W'(1);
              blink_d = BW'(BLINK_FRAMES);
              state_d = HIT;
            end else begin
              lives_d = '0;
              state_d = OVER;
            end
          end else if (life_gain && (lives_q < MAXL)) begin
            lives_d = lives_q + LIVES_W'(1);
          end
        end
        HIT: begin
          // Invulnerable: damage is ignored, pickups still count.
          if (life_gain && (lives_q < MAXL)) begin
            lives_d = lives_q + LIVES_W'(1);
          end
          if (frame_tick && (blink_q != '0)) begin
            blink_d = blink_q - BW'(1);
            if (blink_q == BW'(1)) begin
              state_d = ALIVE;
            end
          end
        end
        OVER: begin
          state_d = OVER;
        end
        default: begin
          state_d = ALIVE;
        end
      endcase
    end

    hit_active_d = (state_d == HIT);
    game_over_d  = (state_d == OVER);
  end

  assign lives       = lives_q;
  assign lives_disp  = lives_disp_q;
  assign state       = state_q;
  assign blink_phase = blink_q[BLINK_BIT];
  assign hit_active  = hit_active_q;
  assign game_over   = game_over_q;

endmodule

// File: rtl/heart_hud_ctrl.sv
// Purpose: player-lives HUD; decodes heart slots, shares one icon ROM, emits RGB565 + opacity.
// Latency: 3 vga_clk from vga_x/vga_y/video_on to rgb/pix_valid. Backpressure: none, streams every cycle.
// Ports: vga_clk, sys_rst_n, hud (heart_hud_if.slave: raster in, events in, ROM addr/data, pixel/lives/flags out).
module heart_hud_ctrl
  import hud_pkg::*;
#(
  parameter int          MAX_LIVES    = 3,
  parameter int          ICON_W       = 16,
  parameter int          ICON_H       = 16,
  parameter int          SCALE        = 2,
  parameter int          START_X      = 20,
  parameter int          START_Y      = 20,
  parameter int          GAP          = 4,
  parameter int          BLINK_FRAMES = 60,
  parameter int          BLINK_BIT    = 2,
  parameter logic [15:0] KEY_COLOR    = KEY_COLOR_DEFAULT
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  heart_hud_if.slave  hud
);

  localparam int DISP_W = ICON_W * SCALE;
  localparam int DISP_H = ICON_H * SCALE;
  localparam int PITCH  = DISP_W + GAP;
  localparam logic [9:0] Y_TOP = 10'(START_Y);
  localparam logic [9:0] Y_END = 10'(START_Y + DISP_H);

  // Frame boundary strobe: first pixel of the first blanking line.
  logic frame_tick;
  assign frame_tick = (hud.vga_x == 10'd0) && (hud.vga_y == 10'(V_ACTIVE));

  logic [LIVES_W-1:0] lives_disp;
  life_state_e        state;
  logic               blink_phase;

  hud_life_fsm #(
    .MAX_LIVES    (MAX_LIVES),
    .BLINK_FRAMES (BLINK_FRAMES),
    .BLINK_BIT    (BLINK_BIT)
  ) u_life_fsm (
    .vga_clk      (vga_clk),
    .sys_rst_n    (sys_rst_n),
    .frame_tick   (frame_tick),
    .life_lost    (hud.life_lost),
    .life_gain    (hud.life_gain),
    .game_restart (hud.game_restart),
    .lives        (hud.lives),
    .lives_disp   (lives_disp),
    .state        (state),
    .blink_phase  (blink_phase),
    .hit_active   (hud.hit_active),
    .game_over    (hud.game_over)
  );

  // ---------------- S1: slot decode and ROM address ----------------
  logic                 s1_hit_q, s1_hit_d;
  logic [LIVES_W-1:0]   s1_slot_q, s1_slot_d;
  logic                 s1_von_q, s1_von_d;
  logic [3:0]           rom_x_q, rom_x_d;
  logic [3:0]           rom_y_q, rom_y_d;
  logic [9:0]           slot_x0;
  logic [9:0]           rel_x;
  logic [9:0]           rel_y;

  always_comb begin
    s1_hit_d  = 1'b0;
    s1_slot_d = '0;
    s1_von_d  = hud.video_on;
    rom_x_d   = '0;
    rom_y_d   = '0;
    slot_x0   = '0;
    rel_x     = '0;
    rel_y     = hud.vga_y - Y_TOP;
    if ((hud.vga_y >= Y_TOP) && (hud.vga_y < Y_END)) begin
      for (int i = 0; i < MAX_LIVES; i++) begin
        slot_x0 = 10'(START_X + i * PITCH);
        if ((hud.vga_x >= slot_x0) && (hud.vga_x < slot_x0 + 10'(DISP_W))) begin
          s1_hit_d  = 1'b1;
          s1_slot_d = LIVES_W'(i);
          rel_x     = hud.vga_x - slot_x0;
        end
      end
    end
    // Misses park the address at 0 so the ROM bus is quiet off-icon.
    if (s1_hit_d) begin
      rom_x_d = 4'(rel_x / 10'(SCALE));
      rom_y_d = 4'(rel_y / 10'(SCALE));
    end
  end

  // ---------------- S2: side-band delayed to meet ROM data ----------------
  logic               s2_hit_q, s2_hit_d;
  logic [LIVES_W-1:0] s2_slot_q, s2_slot_d;
  logic               s2_von_q, s2_von_d;

  always_comb begin
    s2_hit_d  = s1_hit_q;
    s2_slot_d = s1_slot_q;
    s2_von_d  = s1_von_q;
  end

  // ---------------- S3: colour select and registered output ----------------
  logic [15:0] rgb_q, rgb_d;
  logic        pix_valid_q, pix_valid_d;
  logic        full_bright;

  always_comb begin
    // The slot that just lost its heart flashes full during the "on" blink phase.
    full_bright = (s2_slot_q < lives_disp) ||
                  ((state == HIT) && (s2_slot_q == lives_disp) && blink_phase);
    rgb_d       = '0;
    pix_valid_d = 1'b0;
    if (s2_von_q && s2_hit_q && (hud.rom_rgb != KEY_COLOR)) begin
      rgb_d       = full_bright ? hud.rom_rgb : rgb565_dim(hud.rom_rgb);
      pix_valid_d = 1'b1;
    end
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      s1_hit_q    <= 1'b0;
      s1_slot_q   <= '0;
      s1_von_q    <= 1'b0;
      rom_x_q     <= '0;
      rom_y_q     <= '0;
      s2_hit_q    <= 1'b0;
      s2_slot_q   <= '0;
      s2_von_q    <= 1'b0;
      rgb_q       <= '0;
      pix_valid_q <= 1'b0;
    end else begin
      s1_hit_q    <= s1_hit_d;
      s1_slot_q   <= s1_slot_d;
      s1_von_q    <= s1_von_d;
      rom_x_q     <= rom_x_d;
      rom_y_q     <= rom_y_d;
      s2_hit_q    <= s2_hit_d;
      s2_slot_q   <= s2_slot_d;
      s2_von_q    <= s2_von_d;
      rgb_q       <= rgb_d;
      pix_valid_q <= pix_valid_d;
    end
  end

  assign hud.rom_x     = rom_x_q;
  assign hud.rom_y     = rom_y_q;
  assign hud.rgb       = rgb_q;
  assign hud.pix_valid = pix_valid_q;

endmodule

// File: tb/tb_heart_hud_ctrl.sv
// Purpose: self-checking bench for heart_hud_ctrl with a 1-cycle heart ROM model.
// Latency: n/a. Backpressure: n/a.
// Ports: none; drives heart_hud_if directly, raster positions and frame ticks are injected as needed.
module tb_heart_hud_ctrl;
  import hud_pkg::*;

  localparam logic [15:0] GREEN = 16'h07E0;
  localparam logic [15:0] GDIM  = 16'h01E0;
  localparam logic [15:0] KEY   = 16'hF81F;

  logic vga_clk   = 1'b0;
  logic sys_rst_n = 1'b0;

  heart_hud_if hud_if ();

  heart_hud_ctrl dut (
    .vga_clk   (vga_clk),
    .sys_rst_n (sys_rst_n),
    .hud       (hud_if)
  );

  always #5 vga_clk = ~vga_clk;

  // Heart ROM: icon corner texels are transparent, everything else green.
  always @(posedge vga_clk) begin
    if (((hud_if.rom_x == 4'd0) || (hud_if.rom_x == 4'd15)) &&
        ((hud_if.rom_y == 4'd0) || (hud_if.rom_y == 4'd15)))
      hud_if.rom_rgb <= KEY;
    else
      hud_if.rom_rgb <= GREEN;
  end

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        von;
    logic [15:0] rgb;
    logic        pv;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_idle();
    hud_if.vga_x        = 10'd1000;
    hud_if.vga_y        = 10'd1000;
    hud_if.video_on     = 1'b0;
    hud_if.life_lost    = 1'b0;
    hud_if.life_gain    = 1'b0;
    hud_if.game_restart = 1'b0;
  endtask

  // Present one pixel for one cycle, read the result 3 rising edges later.
  task automatic probe(input logic [9:0] x, input logic [9:0] y, input logic von,
                       output logic [15:0] prgb, output logic ppv);
    @(negedge vga_clk);
    hud_if.vga_x    = x;
    hud_if.vga_y    = y;
    hud_if.video_on = von;
    @(negedge vga_clk);
    set_idle();
    @(negedge vga_clk);
    @(negedge vga_clk);
    prgb = hud_if.rgb;
    ppv  = hud_if.pix_valid;
  endtask

  task automatic tick();
    @(negedge vga_clk);
    hud_if.vga_x    = 10'd0;
    hud_if.vga_y    = 10'd480;
    hud_if.video_on = 1'b0;
    @(negedge vga_clk);
    set_idle();
  endtask

  // One-cycle event pulse; returns at the negedge after the consuming edge.
  task automatic pulse(input logic lost, input logic gain, input logic rst);
    @(negedge vga_clk);
    hud_if.life_lost    = lost;
    hud_if.life_gain    = gain;
    hud_if.game_restart = rst;
    @(negedge vga_clk);
    set_idle();
  endtask

  task automatic chk_pix(input string nm, input logic [9:0] x, input logic [9:0] y,
                         input logic [15:0] exp_rgb, input logic exp_pv);
    logic [15:0] r;
    logic        p;
    probe(x, y, 1'b1, r, p);
    chk({nm, ".rgb"}, r, exp_rgb);
    chk({nm, ".pv"}, 16'(p), 16'(exp_pv));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] r;
    logic        p;
    int          bc;

    // (21,21) maps to texel (0,0) at 2x scale, same as (20,20), so it is keyed too.
    tbl[0]  = '{10'd20,  10'd20, 1'b1, 16'h0000, 1'b0};
    tbl[1]  = '{10'd21,  10'd21, 1'b1, 16'h0000, 1'b0};
    tbl[2]  = '{10'd22,  10'd22, 1'b1, GREEN,    1'b1};
    tbl[3]  = '{10'd51,  10'd30, 1'b1, GREEN,    1'b1};
    tbl[4]  = '{10'd52,  10'd30, 1'b1, 16'h0000, 1'b0};
    tbl[5]  = '{10'd55,  10'd30, 1'b1, 16'h0000, 1'b0};
    tbl[6]  = '{10'd56,  10'd30, 1'b1, GREEN,    1'b1};
    tbl[7]  = '{10'd87,  10'd51, 1'b1, 16'h0000, 1'b0};
    tbl[8]  = '{10'd85,  10'd49, 1'b1, GREEN,    1'b1};
    tbl[9]  = '{10'd92,  10'd20, 1'b1, 16'h0000, 1'b0};
    tbl[10] = '{10'd100, 10'd40, 1'b1, GREEN,    1'b1};
    tbl[11] = '{10'd100, 10'd40, 1'b0, 16'h0000, 1'b0};
    tbl[12] = '{10'd124, 10'd30, 1'b1, 16'h0000, 1'b0};
    tbl[13] = '{10'd123, 10'd30, 1'b1, GREEN,    1'b1};
    tbl[14] = '{10'd100, 10'd52, 1'b1, 16'h0000, 1'b0};
    tbl[15] = '{10'd100, 10'd19, 1'b1, 16'h0000, 1'b0};
    tbl[16] = '{10'd19,  10'd30, 1'b1, 16'h0000, 1'b0};
    tbl[17] = '{10'd88,  10'd30, 1'b1, 16'h0000, 1'b0};

    set_idle();
    repeat (3) @(negedge vga_clk);

    // Reset state, checked while reset is still asserted.
    chk("rst.rgb",   hud_if.rgb, 16'h0000);
    chk("rst.pv",    16'(hud_if.pix_valid), 16'd0);
    chk("rst.rom_x", 16'(hud_if.rom_x), 16'd0);
    chk("rst.rom_y", 16'(hud_if.rom_y), 16'd0);
    chk("rst.lives", 16'(hud_if.lives), 16'd3);
    chk("rst.hit",   16'(hud_if.hit_active), 16'd0);
    chk("rst.over",  16'(hud_if.game_over), 16'd0);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge vga_clk);

    // Table sweep with all three hearts full.
    for (int i = 0; i < 18; i++) begin
      probe(tbl[i].x, tbl[i].y, tbl[i].von, r, p);
      chk($sformatf("vec%0d.rgb", i), r, tbl[i].rgb);
      chk($sformatf("vec%0d.pv", i), 16'(p), 16'(tbl[i].pv));
    end

    // Exact latency at (22,22): nothing after 2 edges, pixel after 3, gone after 4.
    @(negedge vga_clk);
    hud_if.vga_x = 10'd22; hud_if.vga_y = 10'd22; hud_if.video_on = 1'b1;
    @(negedge vga_clk);
    set_idle();
    @(negedge vga_clk);
    chk("lat2.pv", 16'(hud_if.pix_valid), 16'd0);
    @(negedge vga_clk);
    chk("lat3.pv", 16'(hud_if.pix_valid), 16'd1);
    chk("lat3.rgb", hud_if.rgb, GREEN);
    @(negedge vga_clk);
    chk("lat4.pv", 16'(hud_if.pix_valid), 16'd0);

    // Gain at full lives saturates.
    pulse(1'b0, 1'b1, 1'b0);
    chk("gain_sat.lives", 16'(hud_if.lives), 16'd3);

    // First hit.
    pulse(1'b1, 1'b0, 1'b0);
    chk("hit1.lives", 16'(hud_if.lives), 16'd2);
    chk("hit1.hit",   16'(hud_if.hit_active), 16'd1);
    chk_pix("hit1.pretick.s2", 10'd100, 10'd40, GREEN, 1'b1);

    // Damage while invulnerable is ignored.
    pulse(1'b1, 1'b0, 1'b0);
    chk("hit2.lives", 16'(hud_if.lives), 16'd2);

    // Blink: after k ticks the counter is 60-k; bit 2 set means full brightness.
    for (int k = 1; k <= 60; k++) begin
      tick();
      bc = 60 - k;
      chk_pix($sformatf("blink%0d.s2", k), 10'd100, 10'd40,
              (((bc >> 2) & 1) == 1 && bc != 0) ? GREEN : GDIM, 1'b1);
      chk($sformatf("blink%0d.hit", k), 16'(hud_if.hit_active), (bc != 0) ? 16'd1 : 16'd0);
      if (k == 1) begin
        chk_pix("blink1.s0", 10'd30, 10'd30, GREEN, 1'b1);
        chk_pix("blink1.s1", 10'd60, 10'd30, GREEN, 1'b1);
      end
    end
    chk_pix("after_hit.s2", 10'd100, 10'd40, GDIM, 1'b1);
    chk("after_hit.lives", 16'(hud_if.lives), 16'd2);

    // Down to one life, then let invulnerability expire.
    pulse(1'b1, 1'b0, 1'b0);
    chk("hit3.lives", 16'(hud_if.lives), 16'd1);
    for (int k = 0; k < 60; k++) tick();
    chk("hit3.end.hit", 16'(hud_if.hit_active), 16'd0);
    chk_pix("one.s0", 10'd30, 10'd30, GREEN, 1'b1);
    chk_pix("one.s1", 10'd60, 10'd30, GDIM, 1'b1);

    // Last life lost.
    pulse(1'b1, 1'b0, 1'b0);
    chk("over.lives", 16'(hud_if.lives), 16'd0);
    chk("over.flag",  16'(hud_if.game_over), 16'd1);
    chk("over.hit",   16'(hud_if.hit_active), 16'd0);
    tick();
    chk_pix("over.s0", 10'd30, 10'd30, GDIM, 1'b1);
    chk_pix("over.s2", 10'd100, 10'd40, GDIM, 1'b1);
    pulse(1'b0, 1'b1, 1'b0);
    chk("over.gain.lives", 16'(hud_if.lives), 16'd0);
    pulse(1'b1, 1'b0, 1'b0);
    chk("over.lost.lives", 16'(hud_if.lives), 16'd0);
    chk("over.lost.flag",  16'(hud_if.game_over), 16'd1);

    // Restart.
    pulse(1'b0, 1'b0, 1'b1);
    chk("restart.lives", 16'(hud_if.lives), 16'd3);
    chk("restart.over",  16'(hud_if.game_over), 16'd0);
    chk("restart.hit",   16'(hud_if.hit_active), 16'd0);

    // Simultaneous lost+gain in ALIVE: the gain is dropped.
    pulse(1'b1, 1'b1, 1'b0);
    chk("both.lives", 16'(hud_if.lives), 16'd2);
    chk("both.hit",   16'(hud_if.hit_active), 16'd1);
    tick();
    chk_pix("both.s2", 10'd100, 10'd40, GDIM, 1'b1);

    // Mid-slot reset while (30,30) is streaming.
    @(negedge vga_clk);
    hud_if.vga_x = 10'd30; hud_if.vga_y = 10'd30; hud_if.video_on = 1'b1;
    repeat (3) @(negedge vga_clk);
    chk("prerst.rgb", hud_if.rgb, GREEN);
    chk("prerst.pv",  16'(hud_if.pix_valid), 16'd1);
    sys_rst_n = 1'b0;
    #1;
    chk("midrst.rgb",   hud_if.rgb, 16'h0000);
    chk("midrst.pv",    16'(hud_if.pix_valid), 16'd0);
    chk("midrst.lives", 16'(hud_if.lives), 16'd3);
    chk("midrst.hit",   16'(hud_if.hit_active), 16'd0);
    @(negedge vga_clk);
    set_idle();
    sys_rst_n = 1'b1;
    chk_pix("postrst.s2", 10'd100, 10'd40, GREEN, 1'b1);
    chk_pix("postrst.s1", 10'd60, 10'd30, GREEN, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
